// File: rtl/uart_boot_pkg.sv
// uart_boot_pkg: state encoding and protocol byte constants for the UART boot loader.
package uart_boot_pkg;
   typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, ACK_OK, ACK_ERR, DONE} boot_state_e;
   localparam logic [7:0] SYNC_BYTE    = 8'hA5;
   localparam logic [7:0] ACK_OK_BYTE  = 8'h4B;
   localparam logic [7:0] ACK_ERR_BYTE = 8'h45;
endpackage

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: loads a UART framed image into ISRAM, holds the core in reset until acked.
// Optional trailing checksum byte enabled by defining BOOT_CHECKSUM_EN.
module uart_boot_loader
   import uart_boot_pkg::*;
#(
   parameter int MEM_WORDS   = 4096,
   parameter int AW          = 12,
   parameter int BASE_WADDR  = 0,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rx_valid,
   input  logic [7:0]    rx_data,
   output logic          tx_valid,
   output logic [7:0]    tx_data,
   input  logic          tx_ready,
   output logic          mem_we,
   output logic [AW-1:0] mem_waddr,
   output logic [31:0]   mem_wdata,
   output logic          core_rst,
   output logic          boot_done,
   output logic          boot_err
);
   localparam int TW = $clog2(TIMEOUT_CYC);
   boot_state_e    state_q, state_d;
   logic [15:0]    len_q, len_d, idx_q, idx_d, len_in;
   logic [1:0]     bcnt_q, bcnt_d;
   logic [31:0]    word_q, word_d, wdata_q, wdata_d;
   logic [TW-1:0]  tmo_q, tmo_d;
   logic [AW-1:0]  waddr_q, waddr_d;
   logic           we_q, we_d, done_q, done_d, err_q, err_d, crst_q, crst_d, timing;
`ifdef BOOT_CHECKSUM_EN
   logic [7:0]     sum_q, sum_d;
`endif
   assign len_in    = {rx_data, len_q[7:0]};
   assign timing    = state_q inside {LEN0, LEN1, DATA, CSUM};
   assign tx_valid  = state_q == ACK_OK || state_q == ACK_ERR;
   assign tx_data   = state_q == ACK_OK ? ACK_OK_BYTE : state_q == ACK_ERR ? ACK_ERR_BYTE : 8'h00;
   assign mem_we    = we_q;
   assign mem_waddr = waddr_q;
   assign mem_wdata = wdata_q;
   assign core_rst  = crst_q;
   assign boot_done = done_q;
   assign boot_err  = err_q;
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      bcnt_d  = bcnt_q;
      word_d  = word_q;
      wdata_d = wdata_q;
      waddr_d = waddr_q;
      we_d    = 1'b0;
      done_d  = done_q;
      err_d   = err_q;
      crst_d  = crst_q;
      tmo_d   = timing && !rx_valid ? tmo_q + TW'(1) : '0;
`ifdef BOOT_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      case (state_q)
         IDLE: if (rx_valid && rx_data == SYNC_BYTE) begin
            state_d = LEN0;
            err_d   = 1'b0;
            idx_d   = '0;
            bcnt_d  = '0;
`ifdef BOOT_CHECKSUM_EN
            sum_d   = '0;
`endif
         end
         LEN0: if (rx_valid) begin
            len_d[7:0] = rx_data;
            state_d    = LEN1;
         end
         LEN1: if (rx_valid) begin
            len_d   = len_in;
            state_d = len_in == '0 ? ACK_OK
                    : 32'(len_in) > 32'(MEM_WORDS - BASE_WADDR) ? ACK_ERR : DATA;
         end
         DATA: if (rx_valid) begin
            word_d = {rx_data, word_q[31:8]};
            bcnt_d = bcnt_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
            sum_d  = sum_q + rx_data;
`endif
            if (bcnt_q == 2'd3) begin
               we_d    = 1'b1;
               wdata_d = word_d;
               waddr_d = AW'(BASE_WADDR) + idx_q[AW-1:0];
               idx_d   = idx_q + 16'd1;
`ifdef BOOT_CHECKSUM_EN
               if (idx_q == len_q - 16'd1) state_d = CSUM;
`else
               if (idx_q == len_q - 16'd1) state_d = ACK_OK;
`endif
            end
         end
`ifdef BOOT_CHECKSUM_EN
         CSUM: if (rx_valid) state_d = rx_data == sum_q ? ACK_OK : ACK_ERR;
`endif
         ACK_OK: if (tx_ready) begin
            state_d = DONE;
            done_d  = 1'b1;
            crst_d  = 1'b0;
         end
         ACK_ERR: if (tx_ready) begin
            state_d = IDLE;
            err_d   = 1'b1;
         end
         default: ;
      endcase
      // a byte landing on the final timeout cycle takes priority
      if (timing && !rx_valid && tmo_q == TW'(TIMEOUT_CYC - 1)) state_d = ACK_ERR;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         bcnt_q  <= '0;
         word_q  <= '0;
         wdata_q <= '0;
         waddr_q <= '0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         crst_q  <= 1'b1;
         tmo_q   <= '0;
`ifdef BOOT_CHECKSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         bcnt_q  <= bcnt_d;
         word_q  <= word_d;
         wdata_q <= wdata_d;
         waddr_q <= waddr_d;
         we_q    <= we_d;
         done_q  <= done_d;
         err_q   <= err_d;
         crst_q  <= crst_d;
         tmo_q   <= tmo_d;
`ifdef BOOT_CHECKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: scoreboard bench for uart_boot_loader, small ISRAM and short timeout.
// Runs the checksum scenario only when BOOT_CHECKSUM_EN is defined.
module tb_uart_boot_loader;
   import uart_boot_pkg::*;
   localparam int MW = 16, AW = 4, TO = 64;
   logic          clk = 0, rst = 1, rx_valid = 0, tx_ready = 0;
   logic [7:0]    rx_data = 0;
   logic          tx_valid, mem_we, core_rst, boot_done, boot_err;
   logic [7:0]    tx_data;
   logic [AW-1:0] mem_waddr;
   logic [31:0]   mem_wdata;
   int vec = 0, err = 0, cyc = 0, last_rx = -10;
   logic [AW+31:0] exp_q[$];
   logic [AW+31:0] e;
   always #5 clk = ~clk;
   uart_boot_loader #(.MEM_WORDS(MW), .AW(AW), .BASE_WADDR(0), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .core_rst(core_rst), .boot_done(boot_done), .boot_err(boot_err));
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rx_valid) last_rx <= cyc;
   end
   // every write must match the oldest expected word and follow its 4th byte by one cycle
   always @(negedge clk) if (mem_we) begin
      vec++;
      if (exp_q.size() == 0) begin
         err++;
         $display("FAIL unexpected_write got addr=%0h data=%08h required no write", mem_waddr, mem_wdata);
      end else begin
         e = exp_q.pop_front();
         if ({mem_waddr, mem_wdata} !== e || last_rx != cyc - 1) begin
            err++;
            $display("FAIL mem_write got addr=%0h data=%08h lat=%0d required addr=%0h data=%08h lat=1",
                     mem_waddr, mem_wdata, cyc - last_rx, e[AW+31:32], e[31:0]);
         end
      end
   end
   task automatic send(input logic [7:0] b, input int gap = 0);
      rx_data = b; rx_valid = 1;
      @(posedge clk); #1 rx_valid = 0;
      repeat (gap) begin @(posedge clk); #1; end
   endtask
   task automatic frame(input logic [15:0] len, input logic [7:0] base, input logic [7:0] step,
                        input bit push, input bit csum_ok);
      logic [7:0] b, s;
      logic [31:0] w;
      s = 0; w = 0;
      send(SYNC_BYTE); send(len[7:0]); send(len[15:8]);
      for (int i = 0; i < int'(len) * 4; i++) begin
         b = 8'(int'(base) + int'(step) * i);
         w = {b, w[31:8]};
         s = s + b;
         if (push && i % 4 == 3) exp_q.push_back({AW'(i / 4), w});
         send(b);
      end
`ifdef BOOT_CHECKSUM_EN
      if (len != 0) send(csum_ok ? s : s + 8'h01);
`endif
   endtask
   task automatic wait_ack(input logic [7:0] exp_b, input string nm, output int n);
      n = 0;
      while (!tx_valid && n < 200) begin @(posedge clk); #1; n++; end
      vec++;
      if (!tx_valid) begin
         err++; $display("FAIL %s ack_timeout got no tx_valid required %02h", nm, exp_b);
      end else if (tx_data !== exp_b) begin
         err++; $display("FAIL %s ack_byte got %02h required %02h", nm, tx_data, exp_b);
      end
      tx_ready = 1; @(posedge clk); #1 tx_ready = 0;
   endtask
   task automatic do_reset();
      rst = 1; repeat (2) @(posedge clk); #1 rst = 0;
      exp_q.delete();
   endtask
   task automatic test_reset();
      rst = 1; repeat (2) @(posedge clk); #1;
      vec++;
      if ({tx_valid, tx_data, mem_we, mem_waddr, mem_wdata, core_rst, boot_done, boot_err} !==
          {1'b0, 8'h00, 1'b0, AW'(0), 32'h0, 1'b1, 1'b0, 1'b0}) begin
         err++; $display("FAIL reset_values got tv=%b td=%02h we=%b crst=%b done=%b err=%b required 0 00 0 1 0 0",
                         tx_valid, tx_data, mem_we, core_rst, boot_done, boot_err);
      end
      rst = 0;
   endtask
   task automatic test_basic();
      int n;
      do_reset();
      exp_q.push_back({AW'(0), 32'h44332211});
      exp_q.push_back({AW'(1), 32'h88776655});
      frame(2, 8'h11, 8'h11, 0, 1);
      vec++;
      if ({core_rst, boot_done} !== 2'b10) begin
         err++; $display("FAIL basic_pre_ack got crst/done=%b required 10", {core_rst, boot_done});
      end
      wait_ack(ACK_OK_BYTE, "basic", n);
      vec++;
      if ({core_rst, boot_done, boot_err} !== 3'b010) begin
         err++; $display("FAIL basic_status got %b required 010", {core_rst, boot_done, boot_err});
      end
      frame(2, 8'h11, 8'h11, 0, 1);
      repeat (3) @(posedge clk); #1;
      vec++;
      if ({tx_valid, core_rst, boot_done} !== 3'b001 || exp_q.size() != 0) begin
         err++; $display("FAIL done_terminal got tv/crst/done=%b pending=%0d required 001 pending=0",
                         {tx_valid, core_rst, boot_done}, exp_q.size());
      end
   endtask
   task automatic test_zero_len();
      int n;
      do_reset();
      frame(0, 8'h00, 8'h00, 1, 1);
      wait_ack(ACK_OK_BYTE, "zero_len", n);
      vec++;
      if ({core_rst, boot_done, boot_err} !== 3'b010) begin
         err++; $display("FAIL zero_len_status got %b required 010", {core_rst, boot_done, boot_err});
      end
   endtask
   task automatic test_len_range();
      int n;
      do_reset();
      send(SYNC_BYTE); send(8'h11); send(8'h00);
      wait_ack(ACK_ERR_BYTE, "len_17", n);
      vec++;
      if ({core_rst, boot_done, boot_err, tx_valid} !== 4'b1010) begin
         err++; $display("FAIL len_17_status got crst/done/err/tv=%b required 1010",
                         {core_rst, boot_done, boot_err, tx_valid});
      end
      frame(16, 8'h01, 8'h07, 1, 1);
      wait_ack(ACK_OK_BYTE, "len_16", n);
      vec++;
      if ({core_rst, boot_done, boot_err} !== 3'b010 || exp_q.size() != 0) begin
         err++; $display("FAIL len_16_status got %b pending=%0d required 010 pending=0",
                         {core_rst, boot_done, boot_err}, exp_q.size());
      end
   endtask
   task automatic test_timeout();
      int n;
      do_reset();
      send(SYNC_BYTE); send(8'h01); send(8'h00); send(8'h11); send(8'h22);
      wait_ack(ACK_ERR_BYTE, "timeout", n);
      vec++;
      if (n != TO || {core_rst, boot_done, boot_err} !== 3'b101) begin
         err++; $display("FAIL timeout_status got wait=%0d status=%b required wait=%0d status=101",
                         n, {core_rst, boot_done, boot_err}, TO);
      end
      frame(1, 8'h10, 8'h01, 1, 1);
      wait_ack(ACK_OK_BYTE, "after_timeout", n);
      vec++;
      if ({core_rst, boot_done, boot_err} !== 3'b010 || exp_q.size() != 0) begin
         err++; $display("FAIL after_timeout_status got %b pending=%0d required 010 pending=0",
                         {core_rst, boot_done, boot_err}, exp_q.size());
      end
   endtask
   task automatic test_byte_wins();
      int n;
      do_reset();
      exp_q.push_back({AW'(0), 32'hEFBEADDE});
      send(SYNC_BYTE); send(8'h01); send(8'h00, TO - 1);
      send(8'hDE, TO - 1); send(8'hAD, TO - 1); send(8'hBE, TO - 1); send(8'hEF, TO - 1);
`ifdef BOOT_CHECKSUM_EN
      send(8'(8'hDE + 8'hAD + 8'hBE + 8'hEF));
`endif
      wait_ack(ACK_OK_BYTE, "byte_wins", n);
      vec++;
      if (boot_done !== 1'b1 || exp_q.size() != 0) begin
         err++; $display("FAIL byte_wins_status got done=%b pending=%0d required done=1 pending=0",
                         boot_done, exp_q.size());
      end
   endtask
`ifdef BOOT_CHECKSUM_EN
   task automatic test_checksum();
      int n;
      do_reset();
      exp_q.push_back({AW'(0), 32'h44332211});
      exp_q.push_back({AW'(1), 32'h88776655});
      frame(2, 8'h11, 8'h11, 0, 0);
      wait_ack(ACK_ERR_BYTE, "bad_csum", n);
      vec++;
      if ({core_rst, boot_done, boot_err} !== 3'b101 || exp_q.size() != 0) begin
         err++; $display("FAIL bad_csum_status got %b pending=%0d required 101 pending=0",
                         {core_rst, boot_done, boot_err}, exp_q.size());
      end
   endtask
`endif
   task automatic test_back_to_back();
      int n;
      do_reset();
      send(8'h00); send(8'hFF); send(8'h3C);
      frame(3, 8'h3C, 8'h5A, 1, 1);
      n = 0;
      while (!tx_valid && n < 20) begin @(posedge clk); #1; n++; end
      for (int i = 0; i < 10; i++) begin
         rx_valid = 1; rx_data = SYNC_BYTE;
         @(posedge clk); #1;
         vec++;
         if ({tx_valid, tx_data, core_rst, boot_done} !== {1'b1, ACK_OK_BYTE, 1'b1, 1'b0}) begin
            err++; $display("FAIL ack_hold cyc=%0d got tv=%b td=%02h crst=%b done=%b required 1 4b 1 0",
                            i, tx_valid, tx_data, core_rst, boot_done);
         end
      end
      rx_valid = 0;
      wait_ack(ACK_OK_BYTE, "b2b", n);
      vec++;
      if ({core_rst, boot_done, boot_err} !== 3'b010 || exp_q.size() != 0) begin
         err++; $display("FAIL b2b_status got %b pending=%0d required 010 pending=0",
                         {core_rst, boot_done, boot_err}, exp_q.size());
      end
   endtask
   task automatic test_mid_rst();
      int n;
      do_reset();
      exp_q.push_back({AW'(0), 32'h44332211});
      send(SYNC_BYTE); send(8'h02); send(8'h00);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
      rst = 1; @(posedge clk); #1 rst = 0;
      vec++;
      if ({tx_valid, mem_we, core_rst, boot_done, boot_err} !== 5'b00100 || exp_q.size() != 0) begin
         err++; $display("FAIL mid_rst got tv/we/crst/done/err=%b pending=%0d required 00100 pending=0",
                         {tx_valid, mem_we, core_rst, boot_done, boot_err}, exp_q.size());
      end
      send(8'h66); send(8'h77); send(8'h88);
      frame(1, 8'hC0, 8'h03, 1, 1);
      wait_ack(ACK_OK_BYTE, "after_rst", n);
      vec++;
      if ({core_rst, boot_done} !== 2'b01 || exp_q.size() != 0) begin
         err++; $display("FAIL after_rst_status got %b pending=%0d required 01 pending=0",
                         {core_rst, boot_done}, exp_q.size());
      end
   endtask
   initial begin
      #2;
      test_reset();
      test_basic();
      test_zero_len();
      test_len_range();
      test_timeout();
      test_byte_wins();
`ifdef BOOT_CHECKSUM_EN
      test_checksum();
`endif
      test_back_to_back();
      test_mid_rst();
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule
